mem_stage_access: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Issues loads/stores to the data-memory port with a req/gnt/rvalid handshake.
- Stalls upstream stages while an access is outstanding.
- Selects writeback data and registers the MEM/WB outputs (reg_write, rd, write data) for the WB stage.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/pipeline_mem_wb.sv | 31 +++
 rtl/mem_stage_access.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    typedef enum logic {
        IDLE        = 1'b0,
        WAIT_RVALID = 1'b1
    } state_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pipeline_mem_wb.sv
// MEM/WB pipeline register. A bubble clears the write enable and destination
// but keeps the previous data word.
module pipeline_mem_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        bubble,
    input  logic        reg_write,
    input  logic [4:0]  rd,
    input  logic [31:0] wr_data,
    output logic        reg_write_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] wb_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_wb <= 1'b0;
            rd_wb        <= '0;
            wb_data      <= '0;
        end else if (bubble) begin
            reg_write_wb <= 1'b0;
            rd_wb        <= '0;
        end else if (load_en) begin
            reg_write_wb <= reg_write;
            rd_wb        <= rd;
            wb_data      <= wr_data;
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM stage: data-memory handshake, upstream stall, writeback select and the
// MEM/WB register feeding the WB stage.
module mem_stage_access
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic [1:0]       mem_to_reg,
    input  logic [31:0]      pc_count,
    input  logic [31:0]      RD2,
    input  logic [31:0]      aluResult,
    input  logic [31:0]      signImm,
    input  logic [4:0]       rd,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             stall,
    output logic             reg_write_wb,
    output logic [4:0]       rd_wb,
    output logic [31:0]      wb_data,
    output logic             misalign_err,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;

    logic        is_store;
    logic        is_load;
    logic        mem_op;
    logic        aligned;
    logic        wb_load;
    logic        wb_bubble;
    logic [31:0] wb_sel_data;

    // Store wins when both store and load are flagged; mem_to_reg is then ignored.
    always_comb begin
        is_store = mem_write;
        is_load  = ~mem_write & (wb_sel_t'(mem_to_reg) == WB_MEM);
        mem_op   = is_store | is_load;
        aligned  = (aluResult[1:0] == 2'b00);
    end

    // Handshake and stall decode; reset forces every strobe low in the same cycle.
    always_comb begin
        dmem_req     = 1'b0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        wb_load      = 1'b0;
        wb_bubble    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (mem_op && !aligned) begin
                        misalign_err = 1'b1;
                        wb_bubble    = 1'b1;
                    end else if (mem_op) begin
                        dmem_req  = 1'b1;
                        stall     = is_load | ~dmem_gnt;
                        wb_bubble = is_load | ~dmem_gnt;
                        wb_load   = is_store & dmem_gnt;
                    end else begin
                        wb_load = 1'b1;
                    end
                end
                WAIT_RVALID: begin
                    if (dmem_rvalid) begin
                        wb_load = 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus_err   = 1'b1;
                        wb_bubble = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        wb_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dmem_we    = dmem_req & is_store;
        dmem_addr  = dmem_req ? aluResult : '0;
        dmem_wdata = dmem_req ? RD2 : '0;
    end

    // Completed stores write back their effective address.
    always_comb begin
        wb_sel_data = aluResult;
        if (state == WAIT_RVALID) begin
            wb_sel_data = dmem_rdata;
        end else if (!is_store) begin
            case (wb_sel_t'(mem_to_reg))
                WB_ALU: wb_sel_data = aluResult;
                WB_MEM: wb_sel_data = aluResult;
                WB_PC4: wb_sel_data = pc_count + PC_INC;
                WB_IMM: wb_sel_data = signImm;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall);
            case (state)
                IDLE: begin
                    if (dmem_req && is_load && dmem_gnt) begin
                        state   <= WAIT_RVALID;
                        tmo_cnt <= '0;
                    end
                end
                WAIT_RVALID: begin
                    if (dmem_rvalid || bus_err) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pipeline_mem_wb u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .load_en      (wb_load),
        .bubble       (wb_bubble),
        .reg_write    (reg_write),
        .rd           (rd),
        .wr_data      (wb_sel_data),
        .reg_write_wb (reg_write_wb),
        .rd_wb        (rd_wb),
        .wb_data      (wb_data)
    );

endmodule
